// File: rtl/bist_pkg.sv
// bist_pkg: shared constants and FSM state type for the BIST pattern generator.
package bist_pkg;
    localparam int LFSR_W = 8;
    localparam logic [7:0] TAP_MASK = 8'hB8;
    localparam logic [7:0] SEED_DEFAULT = 8'h01;
    typedef enum logic [1:0] {IDLE, RUN, DONE} tpg_state_t;
endpackage

// File: rtl/bist_tpg_if.sv
// bist_tpg_if: control/pattern bundle between the BIST controller (master) and the generator (slave).
interface bist_tpg_if #(parameter int LFSR_W = 8, parameter int CNT_W = 9);
    logic start, seed_ld;
    logic [LFSR_W-1:0] seed;
    logic [CNT_W-1:0] npat;
    logic [LFSR_W-1:0] pat;
    logic e0, e1, e2, valid, busy, done;
    modport master(output start, seed_ld, seed, npat, input pat, e0, e1, e2, valid, busy, done);
    modport slave(input start, seed_ld, seed, npat, output pat, e0, e1, e2, valid, busy, done);
endinterface

// File: rtl/bist_lfsr.sv
// bist_lfsr: seedable Fibonacci LFSR x^8+x^6+x^5+x^4+1 with load and step enable.
// BIST_TPG_ALLZERO_EN: de Bruijn extension (period 256, zero seed accepted as-is).
module bist_lfsr #(parameter int LFSR_W = 8) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ld_i,
    input  logic              en_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] cur_o
);
    import bist_pkg::*;
    logic [LFSR_W-1:0] l_q, l_d, seed_eff;
    logic fb;
`ifdef BIST_TPG_ALLZERO_EN
    assign seed_eff = seed_i;
    assign fb = ^(cur_o & LFSR_W'(TAP_MASK)) ^ (cur_o[LFSR_W-2:0] == '0);
`else
    assign seed_eff = (seed_i == '0) ? LFSR_W'(SEED_DEFAULT) : seed_i;
    assign fb = ^(cur_o & LFSR_W'(TAP_MASK));
`endif
    // A load and a step in the same cycle step from the freshly loaded seed.
    assign cur_o = ld_i ? seed_eff : l_q;
    assign l_d = en_i ? {cur_o[LFSR_W-2:0], fb} : cur_o;
    always_ff @(posedge CLK) begin
        if (!RSTn) l_q <= LFSR_W'(SEED_DEFAULT);
        else l_q <= l_d;
    end
endmodule

// File: rtl/bist_tpg.sv
// bist_tpg: BIST test pattern generator driving a programmable run of LFSR patterns with start/busy/done.
// BIST_TPG_ALLZERO_EN (in bist_lfsr) selects the all-zero-inclusive sequence.
module bist_tpg #(parameter int LFSR_W = 8, parameter int CNT_W = 9) (
    input  logic      CLK,
    input  logic      RSTn,
    bist_tpg_if.slave io
);
    import bist_pkg::*;
    tpg_state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [LFSR_W-1:0] pat_q, cur;
    logic valid_q, busy_q, done_q, go, ld, en, nz;
    assign go = (state_q == IDLE) && io.start;
    assign ld = (state_q == IDLE) && io.seed_ld;
    assign nz = io.npat != '0;
    assign en = (go && nz) || (state_q == RUN && cnt_q != '0);
    bist_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
        .CLK(CLK), .RSTn(RSTn), .ld_i(ld), .en_i(en), .seed_i(io.seed), .cur_o(cur)
    );
    // cnt_q holds the patterns still to present after the one currently on pat.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (io.start) begin
                    state_q <= nz ? RUN : DONE;
                    cnt_q   <= nz ? io.npat - 1'b1 : '0;
                    pat_q   <= nz ? cur : pat_q;
                    valid_q <= nz;
                    busy_q  <= 1'b1;
                    done_q  <= !nz;
                end
                RUN: begin
                    state_q <= (cnt_q == '0) ? DONE : RUN;
                    cnt_q   <= (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                    pat_q   <= (cnt_q == '0) ? pat_q : cur;
                    valid_q <= cnt_q != '0;
                    done_q  <= cnt_q == '0;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign io.pat   = pat_q;
    assign io.e0    = pat_q[0];
    assign io.e1    = pat_q[1];
    assign io.e2    = pat_q[2];
    assign io.valid = valid_q;
    assign io.busy  = busy_q;
    assign io.done  = done_q;
endmodule

// File: tb/tb_bist_tpg.sv
// tb_bist_tpg: directed table, corner sequences and randomized runs against a sequence-level model.
module tb_bist_tpg;
    logic CLK, RSTn;
    bist_tpg_if #(.LFSR_W(8), .CNT_W(9)) bus();
    bist_tpg #(.LFSR_W(8), .CNT_W(9)) dut (.CLK(CLK), .RSTn(RSTn), .io(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0, n_bad = 0;
    logic [7:0] m_lfsr = 8'h01;
    logic [7:0] last_pat = 8'h00;
    logic [7:0] got_q[$];

    typedef struct {
        bit         ld;
        logic [7:0] seed;
        int         npat;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    function automatic logic [7:0] step(input logic [7:0] l);
        logic fb;
        fb = l[7] ^ l[5] ^ l[4] ^ l[3];
`ifdef BIST_TPG_ALLZERO_EN
        fb = fb ^ (l[6:0] == 7'd0);
`endif
        return {l[6:0], fb};
    endfunction

    function automatic logic [7:0] seed_map(input logic [7:0] s);
`ifdef BIST_TPG_ALLZERO_EN
        return s;
`else
        return (s == 8'h00) ? 8'h01 : s;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " valid"}, bus.valid, 0);
        chk({nm, " busy"}, bus.busy, 0);
        chk({nm, " done"}, bus.done, 0);
        chk({nm, " pat"}, bus.pat, last_pat);
        chk({nm, " e"}, {bus.e2, bus.e1, bus.e0}, last_pat[2:0]);
    endtask

    task automatic do_run(input bit ld, input logic [7:0] sd, input int n, input int pulse_at);
        got_q.delete();
        bus.start = 1'b1; bus.seed_ld = ld; bus.seed = sd; bus.npat = 9'(n);
        if (ld) m_lfsr = seed_map(sd);
        tick();
        bus.start = 1'b0; bus.seed_ld = 1'b0; bus.seed = 8'($urandom); bus.npat = 9'($urandom);
        for (int c = 1; c <= n + 1; c++) begin
            if (c == pulse_at) begin
                bus.start = 1'b1; bus.seed_ld = 1'b1; bus.seed = 8'h55; bus.npat = 9'd3;
            end
            if (c <= n) begin
                last_pat = m_lfsr;
                m_lfsr = step(m_lfsr);
            end
            chk("run valid", bus.valid, c <= n);
            chk("run busy", bus.busy, 1);
            chk("run done", bus.done, c == n + 1);
            chk("run pat", bus.pat, last_pat);
            chk("run e", {bus.e2, bus.e1, bus.e0}, last_pat[2:0]);
            if (c <= n) got_q.push_back(bus.pat);
            tick();
            if (c == pulse_at) begin bus.start = 1'b0; bus.seed_ld = 1'b0; end
        end
        chk_idle("after run");
    endtask

    vec_t tbl[5];

    initial begin
        bus.start = 1'b0; bus.seed_ld = 1'b0; bus.seed = 8'h00; bus.npat = 9'd0;
        RSTn = 1'b0;
        tick(); tick();
        chk_idle("reset");
        RSTn = 1'b1;

        tbl[0] = '{1, 8'h01, 5, 8'h01, 8'h11};
        tbl[1] = '{0, 8'h00, 2, 8'h23, 8'h47};
        tbl[2] = '{0, 8'h00, 0, 8'h47, 8'h47};
`ifdef BIST_TPG_ALLZERO_EN
        tbl[3] = '{1, 8'h00, 1, 8'h00, 8'h00};
        tbl[4] = '{1, 8'h80, 3, 8'h80, 8'h01};
`else
        tbl[3] = '{1, 8'h00, 1, 8'h01, 8'h01};
        tbl[4] = '{1, 8'h80, 3, 8'h80, 8'h02};
`endif
        for (int i = 0; i < 5; i++) begin
            do_run(tbl[i].ld, tbl[i].seed, tbl[i].npat, -1);
            if (tbl[i].npat > 0) chk("tbl first", got_q[0], tbl[i].exp_first);
            chk("tbl last", bus.pat, tbl[i].exp_last);
            chk("tbl count", got_q.size(), tbl[i].npat);
        end

        begin
            bit seen[256];
            int distinct;
            distinct = 0;
            do_run(1, 8'h5A, 256, -1);
            foreach (got_q[i]) begin
                if (!seen[got_q[i]]) distinct++;
                seen[got_q[i]] = 1'b1;
            end
`ifdef BIST_TPG_ALLZERO_EN
            chk("full distinct", distinct, 256);
`else
            chk("full distinct", distinct, 255);
            chk("full no zero", seen[0], 0);
            chk("full wrap", got_q[255], got_q[0]);
`endif
        end

        do_run(1, 8'h3C, 6, 3);
        do_run(0, 8'h00, 2, 3);

        bus.start = 1'b1; bus.seed_ld = 1'b1; bus.seed = 8'h33; bus.npat = 9'd10;
        tick();
        bus.start = 1'b0; bus.seed_ld = 1'b0;
        tick(); tick();
        chk("pre-reset valid", bus.valid, 1);
        RSTn = 1'b0;
        tick();
        last_pat = 8'h00;
        m_lfsr = 8'h01;
        chk_idle("mid-run reset");
        RSTn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post-reset no done", bus.done, 0);
        end
        do_run(0, 8'h00, 1, -1);
        chk("post-reset lfsr", got_q[0], 8'h01);

        for (int r = 0; r < 30; r++) begin
            int n, p;
            n = $urandom_range(0, 20);
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 1) : -1;
            if ($urandom_range(0, 4) == 0) begin
                bus.seed_ld = 1'b1; bus.seed = 8'($urandom);
                m_lfsr = seed_map(bus.seed);
                tick();
                bus.seed_ld = 1'b0;
                chk_idle("seed load idle");
            end
            do_run(1'($urandom_range(0, 1)), 8'($urandom), n, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bist_tpg.md
# bist_tpg

Built-in self-test pattern generator: the stimulus-side counterpart of the MISR response compactor. Produces a programmable-length run of pseudo-random 8-bit patterns from a seedable Fibonacci LFSR and drives the MISR inputs `e0`/`e1`/`e2` (and the circuit under test) with a start/busy/done handshake. Sits between the BIST control logic and the CUT; the MISR signature is read after `done`.

## Interface
- `LFSR_W`, 8: LFSR and pattern width (taps defined for 8 only)
- `CNT_W`, 9: width of the pattern-count input; max run 2^(CNT_W-1)
- `CLK`  in  1  rising-edge clock
- `RSTn`  in  1  synchronous, active-low reset
- `start`  in  1  begin a run; sampled in IDLE only
- `seed_ld`  in  1  load `seed` into LFSR; honoured in IDLE only
- `seed`  in  8  seed value
- `npat`  in  CNT_W  number of patterns in the run; captured at `start`
- `pat`  out  8  current pattern (registered)
- `e0`, `e1`, `e2`  out  1 each  `pat[0]`, `pat[1]`, `pat[2]` to the MISR
- `valid`  out  1  `pat` is a run pattern this cycle
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse at run completion

## Operation
- States: IDLE, RUN, DONE.
- Feedback: `fb = l[7]^l[5]^l[4]^l[3]` (x^8+x^6+x^5+x^4+1); next = `{l[6:0], fb}`. From 0x01: 01, 02, 04, 08, 11, 23, …; period 255.
- IDLE: `seed_ld` loads `seed`; seed 0x00 is replaced by 0x01 (see Configuration). `start` and `seed_ld` together: seed loads, run starts with the new seed. `start` captures `npat`; npat≠0 → RUN, npat=0 → DONE directly (no `valid`).
- RUN: each cycle presents LFSR state on `pat` with `valid`=1, advances LFSR, decrements counter; counter reaching 0 → DONE.
- DONE: `done`=1, `valid`=0, one cycle → IDLE.
- LFSR is never reset by a run: back-to-back runs continue the sequence unless re-seeded.
- `start` / `seed_ld` outside IDLE: ignored.
- `pat` holds its last value when `valid`=0; `e*` follow `pat`.

## Timing
- Reset (RSTn=0 at edge): state IDLE, LFSR 0x01, counter 0, `pat`=0x00, `e0..e2`=0, `valid`=0, `busy`=0, `done`=0. Reset mid-run aborts with no `done` pulse.
- `start` at edge k → first `valid` pattern (equal to current LFSR, e.g. the seed) in cycle k+1; N patterns in cycles k+1…k+N; `done` in cycle k+N+1; IDLE, next `start` accepted, from edge k+N+2.
- npat=0: `done` in cycle k+1, `busy` high that cycle only.
- `busy` is high from cycle k+1 through the `done` cycle inclusive.
- Max `npat` = 256; counter is CNT_W bits, no wrap-around possible.

## Configuration
- `BIST_TPG_ALLZERO_EN` defined: de Bruijn extension, `fb' = fb ^ (l[6:0]==0)`; period 256 including 0x00 (…, 0x80, 0x00, 0x01, …); seed 0x00 accepted as-is.
- Undefined: plain LFSR, period 255, 0x00 never produced; seed 0x00 remapped to 0x01.

## Structure
- Package `bist_pkg`: `LFSR_W`, tap mask 8'hB8, `SEED_DEFAULT` = 8'h01, state enum `tpg_state_t` {IDLE, RUN, DONE}.
- Sub-module `bist_lfsr`: LFSR register with load, enable, and the feedback (including the `_EN` option); FSM, counter and output registers stay in `bist_tpg`.

## Test plan
- Reset, seed_ld=1 seed=0x01, start npat=5 → `pat` 01,02,04,08,11 with `valid` in cycles 1–5, `done` cycle 6, `busy` cycles 1–6.
- After run above, start npat=2 without re-seed → `pat` 23, 47; then IDLE.
- start npat=0 → `done` next cycle, `valid` never high, `busy` one cycle.
- Seed 0x00: without macro → first pattern 0x01; with macro, seed 0x80 npat=3 → 80, 00, 01.
- npat=256 full run: without macro all 255 nonzero values appear, 256th equals first; with macro all 256 values exactly once.
- `start`/`seed_ld` pulsed mid-run ignored; RSTn=0 mid-run → all outputs 0 next cycle, no `done`, LFSR 0x01.
